instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the byte-addressed instruction memory: owns the PC, drives the memory
//  read address, and buffers fetched words in a small prefetch queue. The decode
//  stage consumes the queue through a valid/ready handshake. Branch redirects flush
//  the queue; illegal fetch addresses raise a sticky fault. Sits between INSTR_MEM and decode.
// PARAMETERS
//  RESET_PC   32'd0   PC value loaded on reset
//  MEM_BYTES  400     instruction memory size in bytes; legal word fetch iff PC+4 <= MEM_BYTES
//  DEPTH      2       prefetch queue entries (power of 2, >=2)
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RST        in   1   reset, asynchronous, active-high
//  IM_ADDR    out  32  read address to instruction memory (combinational = PC)
//  IM_DATA    in   32  instruction word from memory, valid same cycle as IM_ADDR
//  ID_INSTR   out  32  instruction at queue head
//  ID_PC      out  32  byte address of ID_INSTR
//  ID_VALID   out  1   queue head holds a valid instruction
//  ID_READY   in   1   decode accepts head this cycle (pop when ID_VALID&ID_READY)
//  BR_TAKEN   in   1   redirect request from execute, single-cycle pulse
//  BR_TARGET  in   32  redirect byte address, sampled when BR_TAKEN=1
//  FAULT      out  1   sticky: misaligned or out-of-range fetch detected
// BEHAVIOUR
//  Reset (async, any time incl. mid-fetch): PC=RESET_PC, queue empty, state=FETCH,
//   ID_VALID=0, ID_INSTR=0, ID_PC=0, FAULT=0. IM_ADDR=RESET_PC while RST held.
//  States: FETCH (enqueue allowed), FULL (queue full, no pop), HALT (fault; terminal).
//   FETCH->FULL: enqueue makes count==DEPTH without pop. FULL->FETCH: pop occurs.
//   FETCH/FULL->HALT: fault condition. HALT exits only by RST.
//  Fetch: in FETCH, or FULL with pop the same cycle, if PC legal: push {PC,IM_DATA},
//   PC<=PC+4. Full and pop in same cycle: push and pop both happen; count unchanged.
//  Latency: word fetched in cycle N is at ID_* from cycle N+1 if the queue was empty.
//   Steady state with ID_READY=1: one instruction per cycle.
//  Legality: PC[1:0]!=0 or PC+4>MEM_BYTES (32-bit compare, no wrap) -> no push,
//   FAULT<=1, state<=HALT. PC arithmetic is mod 2^32; wrap past 0xFFFFFFFC faults.
//  Branch (BR_TAKEN=1, state!=HALT): highest priority. Pop of head in that cycle is
//   honoured (the branch itself); all other entries flushed; no push; PC<=BR_TARGET;
//   state<=FETCH. ID_VALID=0 next cycle; target word at ID_* two cycles after BR_TAKEN.
//   BR_TARGET legality checked when it becomes PC, not at redirect.
//  HALT: no pushes, BR_TAKEN ignored, queue still drains via handshake; ID_VALID
//   falls once empty. IM_ADDR holds faulting PC.
//  ID_* outputs stable while ID_VALID=1 and ID_READY=0.
// STRUCTURE
//  Package instr_fetch_pkg: state enum {FETCH,FULL,HALT}, WORD_BYTES=4, queue entry
//   struct {pc[31:0], instr[31:0]}.
//  Sub-module fetch_queue: DEPTH-entry sync FIFO with push/pop/flush, full/empty,
//   count; flush takes precedence over push; pop in flush cycle is legal.
//  Top holds PC register, state FSM, legality check, handshake glue.
// TESTING
//  1 Reset, ID_READY=1, mem words 0x11111111,0x22222222.. -> ID_PC 0,4,8.. one per
//    cycle starting 1 cycle after RST release; FAULT=0.
//  2 ID_READY=0 for 5 cycles -> exactly DEPTH=2 entries queued, PC=8, state FULL,
//    ID_INSTR held at 0x11111111; release -> 0,4,8 in order, no gap/duplicate.
//  3 BR_TAKEN with BR_TARGET=0x40 while queue holds PC 0x10,0x14 and ID_READY=1 ->
//    0x10 consumed, 0x14 dropped, ID_VALID=0 one cycle, then ID_PC=0x40,0x44.
//  4 BR_TARGET=0x42 -> FAULT=1 cycle after it becomes PC, no push; later BR_TAKEN
//    ignored; queued entries still drain.
//  5 Sequential run to PC=396 (MEM_BYTES=400) -> word @396 delivered, PC=400 faults.
//  6 RST asserted mid-stream with queue full -> same cycle ID_VALID=0, FAULT=0;
//    after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states and prefetch queue entry.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        FULL,
        HALT
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous prefetch FIFO; flush beats push, and a pop in a flush cycle is legal.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC register, fetch FSM, legality check and decode handshake
// in front of a DEPTH-entry prefetch queue.
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 400,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    output logic [31:0] ID_INSTR,
    output logic [31:0] ID_PC,
    output logic        ID_VALID,
    input  logic        ID_READY,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic        FAULT
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic          r_fault;
    logic          w_fault_set;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_legal;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // 33-bit sum so a PC near 2^32 cannot wrap into a legal-looking address.
    assign w_legal  = (r_pc[1:0] == 2'b00) &&
                      (({1'b0, r_pc} + 33'(WORD_BYTES)) <= 33'(MEM_BYTES));
    assign w_entry  = '{pc: r_pc, instr: IM_DATA};
    assign w_pop    = ~w_empty & ID_READY;
    assign IM_ADDR  = r_pc;
    assign ID_VALID = ~w_empty;
    assign ID_INSTR = w_empty ? '0 : w_head.instr;
    assign ID_PC    = w_empty ? '0 : w_head.pc;
    assign FAULT    = r_fault;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_fault_set  = 1'b0;
        if (r_state != HALT && BR_TAKEN) begin
            w_flush      = 1'b1;
            w_pc_next    = BR_TARGET;
            w_state_next = FETCH;
        end else if ((r_state == FETCH && !w_full) || (r_state == FULL && w_pop)) begin
            if (w_legal) begin
                w_push    = 1'b1;
                w_pc_next = r_pc + 32'(WORD_BYTES);
                if (r_state == FETCH && !w_pop && w_count == CW'(DEPTH - 1))
                    w_state_next = FULL;
            end else begin
                w_fault_set  = 1'b1;
                w_state_next = HALT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_set) r_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl with a combinational instruction memory model.
module tb_instr_fetch_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] IM_ADDR;
    logic [31:0] IM_DATA;
    logic [31:0] ID_INSTR;
    logic [31:0] ID_PC;
    logic        ID_VALID;
    logic        ID_READY;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        FAULT;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    instr_fetch_ctrl #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (400),
        .DEPTH     (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IM_ADDR   (IM_ADDR),
        .IM_DATA   (IM_DATA),
        .ID_INSTR  (ID_INSTR),
        .ID_PC     (ID_PC),
        .ID_VALID  (ID_VALID),
        .ID_READY  (ID_READY),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .FAULT     (FAULT)
    );

    // Word at byte address a is 0x11111111 * (a/4 + 1), truncated to 32 bits.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h11111111 * ((a >> 2) + 32'd1);
    endfunction

    assign IM_DATA = mem_word(IM_ADDR);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        BR_TAKEN = 1'b0;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        ID_READY  = 1'b0;
        BR_TAKEN  = 1'b0;
        BR_TARGET = '0;

        // 1: reset state, then one instruction per cycle
        #2;
        check("rst_valid", ID_VALID, 0);
        check("rst_instr", ID_INSTR, 0);
        check("rst_pc",    ID_PC,    0);
        check("rst_fault", FAULT,    0);
        check("rst_addr",  IM_ADDR,  0);
        step();
        RST      = 1'b0;
        ID_READY = 1'b1;
        check("t1_empty", ID_VALID, 0);
        step(); check("t1_pc0", ID_PC, 32'h0); check("t1_i0", ID_INSTR, 32'h11111111);
        check("t1_v0", ID_VALID, 1);
        step(); check("t1_pc1", ID_PC, 32'h4); check("t1_i1", ID_INSTR, 32'h22222222);
        step(); check("t1_pc2", ID_PC, 32'h8); check("t1_i2", ID_INSTR, 32'h33333333);
        step(); check("t1_pc3", ID_PC, 32'hC); check("t1_i3", ID_INSTR, 32'h44444444);
        check("t1_fault", FAULT, 0);

        // 2: stall for 5 cycles, queue fills to DEPTH, then resumes in order
        ID_READY = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_v",  ID_VALID, 1);
            check("t2_hold_pc", ID_PC,    32'h0);
            check("t2_hold_i",  ID_INSTR, 32'h11111111);
        end
        check("t2_pc_reg", IM_ADDR, 32'h8);
        ID_READY = 1'b1;
        step(); check("t2_pc4",  ID_PC, 32'h4);
        step(); check("t2_pc8",  ID_PC, 32'h8);
        step(); check("t2_pcC",  ID_PC, 32'hC);
        step(); check("t2_pc10", ID_PC, 32'h10);

        // 3: branch while queue holds 0x10,0x14; 0x10 consumed, 0x14 dropped
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h40;
        step();
        BR_TAKEN = 1'b0;
        check("t3_bubble", ID_VALID, 0);
        check("t3_addr",   IM_ADDR,  32'h40);
        step(); check("t3_v40", ID_VALID, 1); check("t3_pc40", ID_PC, 32'h40);
        check("t3_i40", ID_INSTR, mem_word(32'h40));
        step(); check("t3_pc44", ID_PC, 32'h44);

        // 4: misaligned branch target faults once it is the PC; later branches ignored
        do_reset();
        ID_READY = 1'b1;
        step(); check("t4_pc0", ID_PC, 32'h0);
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h42;
        step();
        BR_TAKEN = 1'b0;
        check("t4_nofault_yet", FAULT, 0);
        check("t4_addr42",      IM_ADDR, 32'h42);
        step();
        check("t4_fault", FAULT, 1);
        check("t4_nopush", ID_VALID, 0);
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h80;
        step();
        BR_TAKEN = 1'b0;
        check("t4_br_ignored", IM_ADDR, 32'h42);
        check("t4_sticky",     FAULT,   1);
        step(); check("t4_still_empty", ID_VALID, 0);

        // 5: last legal word at 396 is delivered, PC=400 faults, queue drains in HALT
        do_reset();
        ID_READY = 1'b0;
        step();
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'd388;
        step();
        BR_TAKEN = 1'b0;
        check("t5_flushed", ID_VALID, 0);
        step(); check("t5_pc388", ID_PC, 32'd388);
        step(); check("t5_addr396", IM_ADDR, 32'd396);
        ID_READY = 1'b1;
        step();
        check("t5_pc392",   ID_PC,   32'd392);
        check("t5_addr400", IM_ADDR, 32'd400);
        check("t5_nofault", FAULT,   0);
        step();
        check("t5_pc396", ID_PC,    32'd396);
        check("t5_i396",  ID_INSTR, mem_word(32'd396));
        check("t5_fault", FAULT,    1);
        check("t5_hold",  IM_ADDR,  32'd400);
        ID_READY  = 1'b0;
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h0;
        step();
        BR_TAKEN = 1'b0;
        check("t5_halt_held",  ID_PC,   32'd396);
        check("t5_halt_br",    IM_ADDR, 32'd400);
        ID_READY = 1'b1;
        step();
        check("t5_drained", ID_VALID, 0);
        check("t5_instr0",  ID_INSTR, 0);

        // 6: asynchronous reset mid-cycle with a full queue
        do_reset();
        ID_READY = 1'b0;
        step();
        step();
        check("t6_full_v", ID_VALID, 1);
        check("t6_full_a", IM_ADDR,  32'h8);
        #2;
        RST = 1'b1;
        #1;
        check("t6_async_v",  ID_VALID, 0);
        check("t6_async_f",  FAULT,    0);
        check("t6_async_a",  IM_ADDR,  0);
        check("t6_async_pc", ID_PC,    0);
        step();
        RST      = 1'b0;
        ID_READY = 1'b1;
        step(); check("t6_restart0", ID_PC, 32'h0);
        step(); check("t6_restart4", ID_PC, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
